// File: rtl/mux32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux32_arbiter
// Purpose  : Round-robin burst arbiter driving the select of a 32:1 mux32.
// Revision : 1.0 - initial release
// ============================================================================
module mux32_arbiter #(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      req,
    input  logic [31:0]      last,
    input  logic             out_ready,
    output logic [4:0]       select,
    output logic [31:0]      grant,
    output logic             out_valid,
    output logic [CNT_W-1:0] beat_count,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       select_nxt;
    logic [31:0]      grant_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [4:0]       ptr;
    logic [4:0]       ptr_nxt;

    logic [4:0]       winner;
    logic [4:0]       scan_idx;
    logic             found;
    logic             any_req;
    logic             sel_req;
    logic             sel_last;
    logic             beat;
    logic             at_cap;

    // Circular first-set search starting at the priority pointer.
    always_comb begin
        winner   = ptr;
        scan_idx = ptr;
        found    = 1'b0;
        for (int k = 0; k < 32; k++) begin
            scan_idx = ptr + 5'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req   = |req;
    assign sel_req   = req[select];
    assign sel_last  = last[select];
    assign busy      = (state == GRANT);
    assign out_valid = busy & sel_req;
    assign beat      = out_valid & out_ready;
    assign at_cap    = (beat_count == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            select     <= 5'd0;
            grant      <= 32'd0;
            beat_count <= '0;
            ptr        <= 5'd0;
        end else begin
            state      <= state_nxt;
            select     <= select_nxt;
            grant      <= grant_nxt;
            beat_count <= count_nxt;
            ptr        <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        select_nxt = select;
        grant_nxt  = grant;
        count_nxt  = beat_count;
        ptr_nxt    = ptr;
        case (state)
            IDLE: begin
                grant_nxt = 32'd0;
                count_nxt = '0;
                if (any_req) begin
                    state_nxt  = GRANT;
                    select_nxt = winner;
                    grant_nxt  = 32'd1 << winner;
                end
            end
            GRANT: begin
                // Withdrawal wins over any beat-based release; it never counts a beat.
                if (!sel_req || (beat && (sel_last || at_cap))) begin
                    state_nxt = IDLE;
                    grant_nxt = 32'd0;
                    count_nxt = '0;
                    ptr_nxt   = select + 5'd1;
                end else if (beat) begin
                    count_nxt = beat_count + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 32'd0;
                count_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mux32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux32_arbiter
// Purpose  : Directed bench for mux32_arbiter with a behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux32_arbiter;

    localparam int MAX_BEATS = 8;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      req = 32'd0;
    logic [31:0]      last = 32'd0;
    logic             out_ready = 1'b0;
    logic [4:0]       select;
    logic [31:0]      grant;
    logic             out_valid;
    logic [CNT_W-1:0] beat_count;
    logic             busy;

    int errors = 0;
    int checks = 0;

    mux32_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
        .select(select), .grant(grant), .out_valid(out_valid),
        .beat_count(beat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: who holds the mux, how many beats taken, where the search starts next.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_cnt  = 0;
    int m_ptr  = 0;

    function automatic int rr_winner(input int p, input logic [31:0] r);
        for (int k = 0; k < 32; k++)
            if (r[(p + k) % 32]) return (p + k) % 32;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (req != 32'd0) begin
                m_sel  = rr_winner(m_ptr, req);
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (!req[m_sel] || (out_ready && (last[m_sel] || m_cnt + 1 == MAX_BEATS))) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_ptr  = (m_sel + 1) % 32;
        end else if (out_ready) begin
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_busy",   {31'd0, busy}, {31'd0, m_busy});
        chk("model_select", {27'd0, select}, m_sel);
        chk("model_grant",  grant, m_busy ? (32'd1 << m_sel) : 32'd0);
        chk("model_valid",  {31'd0, out_valid}, {31'd0, m_busy && req[m_sel]});
        chk("model_count",  32'(beat_count), m_cnt);
    end

    // Inputs change 2 time units after a falling edge; returns on the next falling edge.
    task automatic cycle(input logic [31:0] r, input logic [31:0] l, input logic rdy);
        #2;
        req = r; last = l; out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_grant", grant, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_select", {27'd0, select}, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Single burst on requester 5
        cycle(32'h20, 32'd0, 1'b1);
        chk("burst_select", {27'd0, select}, 32'd5);
        chk("burst_grant", grant, 32'h20);
        chk("burst_cnt0", 32'(beat_count), 32'd0);
        cycle(32'h20, 32'd0, 1'b1);
        chk("burst_cnt1", 32'(beat_count), 32'd1);
        cycle(32'h20, 32'd0, 1'b1);
        chk("burst_cnt2", 32'(beat_count), 32'd2);
        cycle(32'h20, 32'h20, 1'b1);
        chk("burst_release", {31'd0, busy}, 32'd0);
        chk("burst_hold_sel", {27'd0, select}, 32'd5);
        cycle(32'd0, 32'd0, 1'b1);

        // Round-robin with wrap, pointer starts at 6
        cycle(32'h8000_0021, ALL, 1'b1);
        chk("rr_first_31", {27'd0, select}, 32'd31);
        cycle(32'h8000_0021, ALL, 1'b1);
        chk("rr_bubble", {31'd0, busy}, 32'd0);
        cycle(32'h8000_0021, ALL, 1'b1);
        chk("rr_second_0", {27'd0, select}, 32'd0);
        cycle(32'h8000_0021, ALL, 1'b1);
        cycle(32'h8000_0021, ALL, 1'b1);
        chk("rr_third_5", {27'd0, select}, 32'd5);
        cycle(32'h8000_0021, ALL, 1'b1);
        cycle(32'h8000_0021, ALL, 1'b1);
        chk("rr_again_31", grant, 32'h8000_0000);
        cycle(32'h8000_0021, ALL, 1'b1);
        cycle(32'd0, 32'd0, 1'b1);

        // Beat cap on requester 7
        cycle(32'h80, 32'd0, 1'b1);
        chk("cap_select", {27'd0, select}, 32'd7);
        for (int i = 1; i < MAX_BEATS; i++) begin
            cycle(32'h80, 32'd0, 1'b1);
            chk("cap_count", 32'(beat_count), i);
        end
        cycle(32'h80, 32'd0, 1'b1);
        chk("cap_release", grant, 32'd0);
        cycle(32'h80, 32'd0, 1'b1);
        chk("cap_regrant", grant, 32'h80);
        cycle(32'd0, 32'd0, 1'b1);

        // Backpressure on requester 2 (pointer at 8 wraps around)
        cycle(32'h4, 32'd0, 1'b1);
        chk("bp_select", {27'd0, select}, 32'd2);
        cycle(32'h4, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(32'h4, 32'd0, 1'b0);
            chk("bp_cnt_frozen", 32'(beat_count), 32'd1);
            chk("bp_grant_held", grant, 32'h4);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        cycle(32'h4, 32'd0, 1'b1);
        chk("bp_resume", 32'(beat_count), 32'd2);
        cycle(32'h4, 32'h4, 1'b1);
        cycle(32'd0, 32'd0, 1'b0);

        // Withdrawal by requester 3; pointer must land on 4
        cycle(32'h8, 32'd0, 1'b1);
        chk("wd_select", {27'd0, select}, 32'd3);
        cycle(32'h8, 32'd0, 1'b1);
        cycle(32'd0, 32'd0, 1'b1);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        chk("wd_cnt", 32'(beat_count), 32'd0);
        cycle(32'h18, 32'd0, 1'b1);
        chk("wd_ptr4", {27'd0, select}, 32'd4);
        cycle(32'h18, 32'h10, 1'b1);
        cycle(32'd0, 32'd0, 1'b1);

        // Asynchronous reset in the middle of a burst on requester 9
        cycle(32'h200, 32'd0, 1'b1);
        chk("ar_select", {27'd0, select}, 32'd9);
        for (int i = 0; i < 3; i++) cycle(32'h200, 32'd0, 1'b1);
        chk("ar_cnt3", 32'(beat_count), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("ar_grant", grant, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_select0", {27'd0, select}, 32'd0);
        chk("ar_cnt0", 32'(beat_count), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        cycle(32'd0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
